aib_io_bank_seq: RTL and testbench

//  Parametrised config sequencer that sits in front of the NumIo AIB IO buffer array.

---
 rtl/aib_io_bank_seq.sv | 171 +++++++++++++++++
 tb/tb_aib_io_bank_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aib_io_bank_seq.sv
// Shadowed per-IO config for an AIB IO bank, committed in GroupSize slices StepCycles apart.
// Optional `AIB_IO_DRV_RAMP_EN: drive strength walks one code per step instead of jumping.
module aib_io_bank_seq #(
  parameter int unsigned NumIo      = 96,
  parameter int unsigned GroupSize  = 16,
  parameter int unsigned StepCycles = 4,
  localparam int unsigned IdxW = (NumIo > 1) ? $clog2(NumIo) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cfg_wr_en,
  input  logic [IdxW-1:0]           i_cfg_wr_idx,
  input  logic                      i_cfg_tx_en,
  input  logic                      i_cfg_ddr_mode,
  input  logic                      i_cfg_async_mode,
  input  logic [3:0]                i_cfg_drv_str,
  input  logic                      i_cfg_pull_up,
  input  logic                      i_cfg_pull_down,
  input  logic                      i_commit_req,
  output logic                      o_busy,
  output logic                      o_commit_ack,
  output logic                      o_cfg_err,
  output logic [NumIo-1:0]          c_io_tx_en,
  output logic [NumIo-1:0]          c_io_ddr_mode,
  output logic [NumIo-1:0]          c_io_async_mode,
  output logic [NumIo-1:0]          c_drv_pull_up,
  output logic [NumIo-1:0]          c_drv_pull_down,
  output logic [NumIo-1:0][3:0]     c_drv_strength
);

  localparam int unsigned NumGroups = (NumIo + GroupSize - 1) / GroupSize;
  localparam int unsigned GrpW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int unsigned StepW     = (StepCycles > 1) ? $clog2(StepCycles) : 1;
  localparam logic [GrpW-1:0]  LastGrp  = GrpW'(NumGroups - 1);
  localparam logic [StepW-1:0] WaitLast = StepW'((StepCycles > 1) ? StepCycles - 2 : 0);

  typedef struct packed {
    logic       tx_en;
    logic       ddr_mode;
    logic       async_mode;
    logic [3:0] drv_str;
    logic       pull_up;
    logic       pull_down;
  } io_cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [GrpW-1:0]       grp_q, grp_d;
  logic [StepW-1:0]      step_q, step_d;
  logic                  settled_q, settled_d;
  logic                  busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  io_cfg_t [NumIo-1:0]   shadow_q, shadow_d, act_q, act_d;
  io_cfg_t               wr_cfg;
  logic                  wr_ok, grp_settled, step_end, step_settled;

`ifdef AIB_IO_DRV_RAMP_EN
  function automatic logic [3:0] drv_step(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt) return cur + 4'd1;
    if (cur > tgt) return cur - 4'd1;
    return cur;
  endfunction
`endif

  assign wr_cfg = {i_cfg_tx_en, i_cfg_ddr_mode, i_cfg_async_mode, i_cfg_drv_str,
                   i_cfg_pull_up, i_cfg_pull_down};
  assign wr_ok  = i_cfg_wr_en && (state_q == S_IDLE) && (32'(i_cfg_wr_idx) < NumIo);

  // Shadow writes and per-group apply; grp_settled reflects the post-apply values.
  always_comb begin
    shadow_d    = shadow_q;
    act_d       = act_q;
    grp_settled = 1'b1;
    for (int unsigned i = 0; i < NumIo; i++) begin
      if (wr_ok && (i_cfg_wr_idx == IdxW'(i))) shadow_d[i] = wr_cfg;
      if ((state_q == S_APPLY) && (grp_q == GrpW'(i / GroupSize))) begin
        act_d[i] = shadow_q[i];
`ifdef AIB_IO_DRV_RAMP_EN
        act_d[i].drv_str = drv_step(act_q[i].drv_str, shadow_q[i].drv_str);
        if (act_d[i].drv_str != shadow_q[i].drv_str) grp_settled = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    step_d       = step_q;
    settled_d    = settled_q;
    // With StepCycles==1 there is no WAIT; the step ends in APPLY itself.
    step_end     = ((state_q == S_APPLY) && (StepCycles == 1)) ||
                   ((state_q == S_WAIT) && (step_q == WaitLast));
    step_settled = (state_q == S_APPLY) ? grp_settled : settled_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_commit_req) begin
          state_d = S_APPLY;
          grp_d   = '0;
        end
      end
      S_APPLY: begin
        settled_d = grp_settled;
        step_d    = '0;
        if (StepCycles > 1) state_d = S_WAIT;
      end
      S_WAIT:  step_d  = step_q + 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (step_end) begin
      if (!step_settled) begin
        state_d = S_APPLY;
      end else if (grp_q == LastGrp) begin
        state_d = S_DONE;
      end else begin
        state_d = S_APPLY;
        grp_d   = grp_q + 1'b1;
      end
    end
    busy_d = (state_q != S_IDLE);
    ack_d  = (state_q == S_DONE);
    err_d  = i_cfg_wr_en && !wr_ok;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      grp_q     <= '0;
      step_q    <= '0;
      settled_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
      act_q     <= '0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      step_q    <= step_d;
      settled_q <= settled_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      act_q     <= act_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_commit_ack = ack_q;
  assign o_cfg_err    = err_q;

  always_comb begin
    c_io_tx_en      = '0;
    c_io_ddr_mode   = '0;
    c_io_async_mode = '0;
    c_drv_pull_up   = '0;
    c_drv_pull_down = '0;
    c_drv_strength  = '0;
    for (int unsigned i = 0; i < NumIo; i++) begin
      c_io_tx_en[i]      = act_q[i].tx_en;
      c_io_ddr_mode[i]   = act_q[i].ddr_mode;
      c_io_async_mode[i] = act_q[i].async_mode;
      c_drv_pull_up[i]   = act_q[i].pull_up;
      c_drv_pull_down[i] = act_q[i].pull_down;
      c_drv_strength[i]  = act_q[i].drv_str;
    end
  end

endmodule

// File: tb/tb_aib_io_bank_seq.sv
// Directed bench: 96/16/4 bank, 20/8/4 partial-group bank, 4/4/1 single-group bank.
module tb_aib_io_bank_seq;

`ifdef AIB_IO_DRV_RAMP_EN
  localparam bit Ramp = 1'b1;
`else
  localparam bit Ramp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [6:0] idx;
  logic tx, ddr, asy, pu, pd;
  logic [3:0] drv;
  logic wen_a, wen_b, wen_c, req_a, req_b, req_c;

  logic busy_a, ack_a, err_a, busy_b, ack_b, err_b, busy_c, ack_c, err_c;
  logic [95:0] tx_a, ddr_a, asy_a, pu_a, pd_a;
  logic [95:0][3:0] drv_a;
  logic [19:0] tx_b, ddr_b, asy_b, pu_b, pd_b;
  logic [19:0][3:0] drv_b;
  logic [3:0] tx_c, ddr_c, asy_c, pu_c, pd_c;
  logic [3:0][3:0] drv_c;

  always #5 clk = ~clk;

  aib_io_bank_seq #(.NumIo(96), .GroupSize(16), .StepCycles(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_cfg_wr_en(wen_a), .i_cfg_wr_idx(idx),
    .i_cfg_tx_en(tx), .i_cfg_ddr_mode(ddr), .i_cfg_async_mode(asy), .i_cfg_drv_str(drv),
    .i_cfg_pull_up(pu), .i_cfg_pull_down(pd), .i_commit_req(req_a),
    .o_busy(busy_a), .o_commit_ack(ack_a), .o_cfg_err(err_a),
    .c_io_tx_en(tx_a), .c_io_ddr_mode(ddr_a), .c_io_async_mode(asy_a),
    .c_drv_pull_up(pu_a), .c_drv_pull_down(pd_a), .c_drv_strength(drv_a));

  aib_io_bank_seq #(.NumIo(20), .GroupSize(8), .StepCycles(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_cfg_wr_en(wen_b), .i_cfg_wr_idx(idx[4:0]),
    .i_cfg_tx_en(tx), .i_cfg_ddr_mode(ddr), .i_cfg_async_mode(asy), .i_cfg_drv_str(drv),
    .i_cfg_pull_up(pu), .i_cfg_pull_down(pd), .i_commit_req(req_b),
    .o_busy(busy_b), .o_commit_ack(ack_b), .o_cfg_err(err_b),
    .c_io_tx_en(tx_b), .c_io_ddr_mode(ddr_b), .c_io_async_mode(asy_b),
    .c_drv_pull_up(pu_b), .c_drv_pull_down(pd_b), .c_drv_strength(drv_b));

  aib_io_bank_seq #(.NumIo(4), .GroupSize(4), .StepCycles(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_cfg_wr_en(wen_c), .i_cfg_wr_idx(idx[1:0]),
    .i_cfg_tx_en(tx), .i_cfg_ddr_mode(ddr), .i_cfg_async_mode(asy), .i_cfg_drv_str(drv),
    .i_cfg_pull_up(pu), .i_cfg_pull_down(pd), .i_commit_req(req_c),
    .o_busy(busy_c), .o_commit_ack(ack_c), .o_cfg_err(err_c),
    .c_io_tx_en(tx_c), .c_io_ddr_mode(ddr_c), .c_io_async_mode(asy_c),
    .c_drv_pull_up(pu_c), .c_drv_pull_down(pd_c), .c_drv_strength(drv_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [6:0] i, input logic t, input logic [3:0] d);
    idx = i; tx = t; drv = d; ddr = 1'b0; asy = t; pu = t; pd = 1'b0;
  endtask

  logic [95:0] exp_tx;
  logic [95:0][3:0] exp_drv;
  int n_grp, ack_cnt, ack_edge, last;

  initial begin
    rst = 1'b1; wen_a = 0; wen_b = 0; wen_c = 0; req_a = 0; req_b = 0; req_c = 0;
    set_cfg(7'd0, 1'b1, 4'hF);
    wen_a = 1'b1;
    tick; tick;
    chk("rst_a_out", 384'({|tx_a, |ddr_a, |asy_a, |pu_a, |pd_a, |drv_a}), 384'(0));
    chk("rst_a_flags", 384'({busy_a, ack_a, err_a}), 384'(0));
    chk("rst_b_out", 384'({|tx_b, |ddr_b, |asy_b, |pu_b, |pd_b, |drv_b, busy_b, ack_b, err_b}), 384'(0));
    chk("rst_c_out", 384'({|tx_c, |ddr_c, |asy_c, |pu_c, |pd_c, |drv_c, busy_c, ack_c, err_c}), 384'(0));
    rst = 1'b0; wen_a = 1'b0;
    // Commit right after reset: a write made during reset must not show up.
    req_a = 1'b1; tick; req_a = 1'b0;
    repeat (25) tick;
    chk("rst_wr_ign_ack", 384'(ack_a), 384'(1));
    chk("rst_wr_ign_tx", 384'(tx_a), 384'(0));
    chk("rst_wr_ign_drv", 384'(drv_a), 384'(0));
    tick;

    // Partial last group on the 20/8/4 bank.
    set_cfg(7'd0, 1'b1, 4'h2); wen_b = 1'b1; tick;
    for (int i = 16; i < 20; i++) begin set_cfg(7'(i), 1'b1, 4'h7); tick; end
    wen_b = 1'b0; req_b = 1'b1; tick; req_b = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick;
      chk("b_tx", 384'(tx_b), 384'((e >= 9) ? 20'hF0001 : 20'h00001));
      chk("b_ack", 384'(ack_b), 384'(e == 13));
      chk("b_busy", 384'(busy_b), 384'(e <= 13));
    end
    chk("b_drv", 384'(drv_b), 384'(80'h7777_0000_0000_0000_0002));

    // Single group, StepCycles=1: ramp up to 15 then back down to 3.
    set_cfg(7'd0, 1'b1, 4'hF); wen_c = 1'b1; tick; wen_c = 1'b0;
    req_c = 1'b1; tick; req_c = 1'b0;
    last = Ramp ? 15 : 1;
    for (int e = 1; e <= last + 2; e++) begin
      tick;
      chk("c_up_drv", 384'(drv_c[0]), 384'((Ramp && e < 15) ? 4'(e) : 4'hF));
      chk("c_up_ack", 384'(ack_c), 384'(e == last + 1));
    end
    chk("c_up_tx", 384'(tx_c), 384'(4'h1));
    chk("c_io1_drv", 384'(drv_c[1]), 384'(0));
    set_cfg(7'd0, 1'b1, 4'h3); wen_c = 1'b1; tick; wen_c = 1'b0;
    req_c = 1'b1; tick; req_c = 1'b0;
    last = Ramp ? 12 : 1;
    for (int e = 1; e <= last + 2; e++) begin
      tick;
      chk("c_dn_drv", 384'(drv_c[0]), 384'((Ramp && (15 - e) > 3) ? 4'(15 - e) : 4'h3));
      chk("c_dn_ack", 384'(ack_c), 384'(e == last + 1));
    end

    // Full 96-IO commit, one group of 16 every 4 cycles.
    for (int i = 0; i < 96; i++) begin set_cfg(7'(i), 1'b1, 4'hA); wen_a = 1'b1; tick; end
    wen_a = 1'b0; req_a = 1'b1; tick; req_a = 1'b0;
    chk("a_e0_tx", 384'(tx_a), 384'(0));
    chk("a_e0_busy", 384'(busy_a), 384'(0));
    for (int e = 1; e <= 27; e++) begin
      tick;
      n_grp = (e - 1) / 4 + 1;
      if (n_grp > 6) n_grp = 6;
      exp_tx = (96'(1) << (16 * n_grp)) - 96'(1);
      for (int i = 0; i < 96; i++) exp_drv[i] = exp_tx[i] ? 4'hA : 4'h0;
      chk("a_tx", 384'(tx_a), 384'(exp_tx));
      chk("a_drv", 384'(drv_a), 384'(exp_drv));
      chk("a_busy", 384'(busy_a), 384'(e <= 25));
      chk("a_ack", 384'(ack_a), 384'(e == 25));
    end

    // Error pulses, write during busy, commit_req while busy, write+commit together.
    set_cfg(7'd100, 1'b0, 4'h3); wen_a = 1'b1; tick; wen_a = 1'b0;
    chk("err_idx", 384'(err_a), 384'(1));
    tick;
    chk("err_idx_clr", 384'(err_a), 384'(0));
    set_cfg(7'd5, 1'b0, 4'h3); wen_a = 1'b1; tick; wen_a = 1'b0;
    chk("err_valid_wr", 384'(err_a), 384'(0));
    set_cfg(7'd7, 1'b0, 4'h1); wen_a = 1'b1; req_a = 1'b1; tick; wen_a = 1'b0; req_a = 1'b0;
    ack_cnt = 0; ack_edge = -1;
    for (int e = 1; e <= 40; e++) begin
      tick;
      if (ack_a) begin ack_cnt++; ack_edge = e; end
      if (e == 3) chk("err_busy", 384'(err_a), 384'(1));
      wen_a = 1'b0; req_a = 1'b0;
      if (e == 2) begin set_cfg(7'd6, 1'b0, 4'h5); wen_a = 1'b1; end
      if (e == 5) req_a = 1'b1;
    end
    chk("ack_once", 384'(ack_cnt), 384'(1));
    chk("ack_edge", 384'(ack_edge), 384'(25));
    exp_tx = '1; exp_tx[5] = 1'b0; exp_tx[7] = 1'b0;
    for (int i = 0; i < 96; i++) exp_drv[i] = 4'hA;
    exp_drv[5] = 4'h3; exp_drv[7] = 4'h1;
    chk("a2_tx", 384'(tx_a), 384'(exp_tx));
    chk("a2_drv", 384'(drv_a), 384'(exp_drv));

    // Reset at edge 10 of a commit.
    req_a = 1'b1; tick; req_a = 1'b0;
    repeat (9) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_tx", 384'(tx_a), 384'(0));
    chk("midrst_drv", 384'(drv_a), 384'(0));
    chk("midrst_flags", 384'({busy_a, ack_a, |pu_a, |asy_a}), 384'(0));
    ack_cnt = 0;
    for (int e = 0; e < 30; e++) begin tick; if (ack_a) ack_cnt++; end
    chk("midrst_no_ack", 384'(ack_cnt), 384'(0));
    chk("midrst_tx_hold", 384'(tx_a), 384'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
